// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one byte with odd parity on device clock falling edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [7:0] din,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INHIBIT  = 3'd1;
  localparam logic [2:0] REQ      = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] ACK      = 3'd4;
  localparam logic [2:0] WAIT_REL = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic data_s1_q, data_s2_q;
  logic fall;
  logic tmo;

  assign fall = clk_s3_q & ~clk_s2_q;
  assign tmo  = (cnt_q == TMO_LAST);

  // NOTE: synchronizer flops reset to 1 (idle bus level) so deasserting reset
  // can never look like a device clock falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_in;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      data_s1_q <= ps2_data_in;
      data_s2_q <= data_s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (strobe) begin
          shift_d   = {~^din, din};
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // The first device edge already shifts out data bit 0.
        if (fall) begin
          cnt_d     = '0;
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
          state_d   = SHIFT;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (fall) begin
          cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!data_s2_q) begin
            state_d = WAIT_REL;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      WAIT_REL: begin
        if (clk_s2_q && data_s2_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any timeout in a bus-active state lands here: release the bus and flag it.
    if (state_q inside {REQ, SHIFT, ACK, WAIT_REL} && !fall && tmo &&
        !(state_q == WAIT_REL && clk_s2_q && data_s2_q)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the captured frame is compared against one built from the byte's bit rules.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe;
  logic [7:0] din;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic       dev_clk, dev_data;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .din(din),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done || err) check("done_err_exclusive", {31'd0, done & err}, 32'd0);
  end

  // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic run_frame(input logic [7:0] b, input bit ack, input bit poke, input bit abort);
    logic [10:0] got;
    int n, d0, e0;
    got = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    din = b;
    strobe = 1'b1;
    cyc(1);
    strobe = 1'b0;
    check("busy_after_strobe", {31'd0, busy}, 32'd1);
    n = 0;
    while (ps2_clk_oe && n < 4 * INH) begin
      n++;
      cyc(1);
    end
    check("inhibit_len", n, INH);
    got[0] = ps2_data_in;
    cyc(4);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      cyc(HALF);
      if (poke && k == 5) begin
        din = 8'hFF;
        strobe = 1'b1;
        cyc(1);
        strobe = 1'b0;
      end
      if (abort && k == 5) begin
        #2 rst = 1'b1;
        #1;
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        cyc(3);
        dev_clk = 1'b1;
        rst = 1'b0;
        cyc(5);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_err", err_cnt - e0, 0);
        return;
      end
      dev_clk = 1'b1;
      got[k] = ps2_data_in;
      cyc(HALF);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    cyc(3);
    dev_clk = 1'b0;
    cyc(HALF);
    dev_clk = 1'b1;
    cyc(3);
    dev_data = 1'b1;
    cyc(20);
    check("frame", {21'd0, got}, {21'd0, model_frame(b)});
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("clk_oe_end", {31'd0, ps2_clk_oe}, 32'd0);
    check("data_oe_end", {31'd0, ps2_data_oe}, 32'd0);
  endtask

  task automatic run_timeout(input logic [7:0] b);
    int n;
    din = b;
    strobe = 1'b1;
    cyc(1);
    strobe = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 4 * INH) begin
      n++;
      cyc(1);
    end
    check("req_start_bit", {31'd0, ps2_data_oe}, 32'd1);
    n = 0;
    while (!err && n < 2 * TMO) begin
      cyc(1);
      n++;
    end
    check("timeout_len", n, TMO);
    check("tmo_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("tmo_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    cyc(1);
    check("tmo_err_one_cycle", {31'd0, err}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    strobe = 1'b0;
    din = 8'h00;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    cyc(3);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("reset_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    rst = 1'b0;
    cyc(3);

    run_frame(8'h55, 1'b1, 1'b0, 1'b0);
    run_frame(8'hED, 1'b1, 1'b0, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0, 1'b0);
    run_timeout(8'h3C);
    cyc(5);
    run_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    run_frame(8'h12, 1'b1, 1'b0, 1'b1);
    run_frame(8'hF4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      cyc($urandom_range(1, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000: the number of clk cycles PS/2 clock is held low before a request (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000: the maximum number of clk cycles between consecutive device clock falling edges, or from request to first edge (2 ms at 50 MHz).
REQ-003 Port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port strobe, input, 1 bit: start request; a one-cycle pulse when idle launches transmission of din.
REQ-006 Port din, input, 8 bits: command byte to send (e.g. 0xED set-LEDs), sampled on the accepted strobe.
REQ-007 Port ps2_clk_in, input, 1 bit: raw PS/2 clock line level, asynchronous to clk.
REQ-008 Port ps2_data_in, input, 1 bit: raw PS/2 data line level, asynchronous to clk.
REQ-009 Port ps2_clk_oe, output, 1 bit: 1 = drive PS/2 clock low (open-drain); 0 = release.
REQ-010 Port ps2_data_oe, output, 1 bit: 1 = drive PS/2 data low (open-drain); 0 = release.
REQ-011 Port busy, output, 1 bit: high from the cycle after an accepted strobe until return to IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse when the frame completes with device ACK.
REQ-013 Port err, output, 1 bit: one-cycle pulse on missing ACK or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a device clock falling edge SHALL be detected as synchronized 1 followed by 0.
REQ-015 The block SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL.
REQ-016 In IDLE, strobe=1 SHALL latch din, compute odd parity (parity = ~^din), and enter INHIBIT on the next edge; strobe while busy SHALL be ignored.
REQ-017 In INHIBIT, ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then the block enters REQ.
REQ-018 In REQ, ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0, and the block waits for the first device falling edge, then enters SHIFT.
REQ-019 In SHIFT, on falling edges 1..8 ps2_data_oe SHALL equal ~din[k-1] (LSB first); on edge 9, ~parity; on edge 10, 0 (stop bit released); then the block enters ACK.
REQ-020 In ACK, on the next falling edge, synchronized data 0 SHALL move to WAIT_REL; data 1 SHALL pulse err and return to IDLE.
REQ-021 In WAIT_REL, once synchronized clock and data are both 1, the block SHALL pulse done and return to IDLE.
REQ-022 A timeout counter SHALL reset on every falling edge and on state entry; reaching TIMEOUT_CYCLES in REQ, SHIFT, ACK or WAIT_REL SHALL release both lines, pulse err, and return to IDLE.
REQ-023 ps2_data_oe SHALL change only in the cycle after a detected falling edge, or on state entry/exit; it SHALL never change while the device clock is high within SHIFT.
REQ-024 busy SHALL be 0 in IDLE and 1 in all other states; done and err SHALL never be asserted together.

Reset
REQ-025 rst=1 SHALL immediately force the IDLE state, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, all counters and the shift register to 0, and synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL release both lines asynchronously with no done or err pulse; the first strobe after deassertion SHALL start a fresh frame.

Verification
REQ-027 din=0x55, device model clocks 11 edges with ACK low -> observed data bits 1,0,1,0,1,0,1,0 LSB-first, parity 1, stop bit 1, then done=1 for one cycle and busy=0.
REQ-028 din=0xED -> clk held low for exactly INHIBIT_CYCLES cycles, start bit 0, bits 1,0,1,1,0,1,1,1, parity 1, done pulse.
REQ-029 din=0x00 and device leaves data high at the ACK edge -> parity bit 1, err=1 for one cycle, done=0, both oe outputs 0.
REQ-030 The device never clocks after REQ -> err pulse exactly TIMEOUT_CYCLES cycles after REQ entry, and lines released.
REQ-031 A second strobe with din=0xFF during SHIFT -> ignored; the frame in flight completes with the original byte.
REQ-032 rst pulsed after edge 5 -> oe outputs 0 within the reset cycle, no done or err; next strobe with din=0xF4 -> complete correct frame.
